// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - assembles scanner key events into multi-digit entries handed off on valid/ready
// Optional inactivity timeout is built only when ENTRY_TIMEOUT_EN is defined.
module keypad_entry_ctrl #(
    parameter int MAX_DIGITS  = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           key_valid,
    input  logic [3:0]                     key_code,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [4*MAX_DIGITS-1:0]        out_digits,
    output logic [$clog2(MAX_DIGITS+1)-1:0] out_count,
    output logic [3:0]                     out_cmd,
    output logic                           busy,
    output logic                           overflow,
    output logic                           key_dropped,
    output logic                           timeout
);

    localparam int DW = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);

    if (MAX_DIGITS < 1 || MAX_DIGITS > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("keypad_entry_ctrl: illegal MAX_DIGITS or TIMEOUT_CYC");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          state_q;
    logic            kv_q;
    logic [DW-1:0]   buffer_q;
    logic [CW-1:0]   count_q;
    logic [3:0]      cmd_q;
    logic            out_valid_q;
    logic            busy_q;
    logic            overflow_q;
    logic            key_dropped_q;
    logic            timeout_q;

    logic            ev;
    logic            is_digit;
    logic            buf_full;
    logic [DW-1:0]   buffer_d;
    logic [CW-1:0]   count_d;
    logic            idle_expired;

    assign ev       = key_valid & ~kv_q;
    assign is_digit = (key_code <= 4'd9);
    assign buf_full = (count_q == CW'(MAX_DIGITS));
    // Shift written as a whole-vector shift so MAX_DIGITS=1 needs no empty slice.
    assign buffer_d = (buffer_q << 4) | DW'(key_code);
    assign count_d  = count_q + CW'(1);

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] idle_cnt_q;

    assign idle_expired = (state_q == S_ENTRY) && (idle_cnt_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || state_q != S_ENTRY || ev || idle_expired) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + TW'(1);
        end
    end
`else
    assign idle_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            kv_q          <= 1'b1;
            buffer_q      <= '0;
            count_q       <= '0;
            cmd_q         <= 4'h0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            overflow_q    <= 1'b0;
            key_dropped_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            kv_q          <= key_valid;
            overflow_q    <= 1'b0;
            key_dropped_q <= 1'b0;
            timeout_q     <= 1'b0;
            case (state_q)
                S_IDLE, S_ENTRY: begin
                    if (ev) begin
                        if (is_digit) begin
                            if (buf_full) begin
                                overflow_q <= 1'b1;
                            end else begin
                                buffer_q <= buffer_d;
                                count_q  <= count_d;
                                state_q  <= S_ENTRY;
                                busy_q   <= 1'b1;
                            end
                        end else if (key_code == 4'hE) begin
                            buffer_q <= '0;
                            count_q  <= '0;
                            state_q  <= S_IDLE;
                            busy_q   <= 1'b0;
                        end else if (key_code == 4'hF) begin
                            // '#' on an empty buffer is silently ignored.
                            if (count_q != '0) begin
                                cmd_q       <= key_code;
                                out_valid_q <= 1'b1;
                                state_q     <= S_HOLD;
                                busy_q      <= 1'b1;
                            end
                        end else begin
                            cmd_q       <= key_code;
                            out_valid_q <= 1'b1;
                            state_q     <= S_HOLD;
                            busy_q      <= 1'b1;
                        end
                    end else if (idle_expired) begin
                        buffer_q  <= '0;
                        count_q   <= '0;
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (ev) begin
                        key_dropped_q <= 1'b1;
                    end
                    if (out_ready) begin
                        buffer_q    <= '0;
                        count_q     <= '0;
                        cmd_q       <= 4'h0;
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    buffer_q    <= '0;
                    count_q     <= '0;
                    cmd_q       <= 4'h0;
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_digits  = buffer_q;
    assign out_count   = count_q;
    assign out_cmd     = cmd_q;
    assign busy        = busy_q;
    assign overflow    = overflow_q;
    assign key_dropped = key_dropped_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - table-driven bench for keypad_entry_ctrl (MAX_DIGITS=4, TIMEOUT_CYC=50)
module tb_keypad_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_digits;
    logic [2:0]  out_count;
    logic [3:0]  out_cmd;
    logic        busy;
    logic        overflow;
    logic        key_dropped;
    logic        timeout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    keypad_entry_ctrl #(.MAX_DIGITS(4), .TIMEOUT_CYC(50)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_digits(out_digits),
        .out_count(out_count), .out_cmd(out_cmd), .busy(busy), .overflow(overflow),
        .key_dropped(key_dropped), .timeout(timeout)
    );

    typedef struct {
        logic        kv;
        logic [3:0]  code;
        logic        rdy;
        logic [27:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [27:0] pk(input logic ov, input logic [15:0] dig, input logic [2:0] cnt,
                                       input logic [3:0] cmd, input logic bsy, input logic ovf,
                                       input logic kd, input logic to);
        return {ov, dig, cnt, cmd, bsy, ovf, kd, to};
    endfunction

    function automatic logic [27:0] act();
        return pk(out_valid, out_digits, out_count, out_cmd, busy, overflow, key_dropped, timeout);
    endfunction

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic add(input logic kv, input logic [3:0] code, input logic rdy, input logic [27:0] e);
        vecs.push_back('{kv: kv, code: code, rdy: rdy, exp: e});
    endtask

    // Press row then release row; the release row expects the same state with pulses cleared.
    task automatic key(input logic [3:0] code, input logic rdy, input logic ov, input logic [15:0] dig,
                       input logic [2:0] cnt, input logic [3:0] cmd, input logic bsy,
                       input logic ovf, input logic kd);
        add(1'b1, code, rdy, pk(ov, dig, cnt, cmd, bsy, ovf, kd, 1'b0));
        add(1'b0, 4'h0, 1'b0, pk(ov, dig, cnt, cmd, bsy, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int pulse_at;
        logic [27:0] zero;
        zero = '0;

        add(1'b0, 4'h0, 1'b0, zero);
        key(4'h1, 0, 0, 16'h0001, 3'd1, 4'h0, 1, 0, 0);
        key(4'h2, 0, 0, 16'h0012, 3'd2, 4'h0, 1, 0, 0);
        key(4'h3, 0, 0, 16'h0123, 3'd3, 4'h0, 1, 0, 0);
        key(4'hF, 0, 1, 16'h0123, 3'd3, 4'hF, 1, 0, 0);
        for (int i = 0; i < 9; i++) add(1'b0, 4'h0, 1'b0, pk(1, 16'h0123, 3'd3, 4'hF, 1, 0, 0, 0));
        add(1'b0, 4'h0, 1'b1, zero);
        add(1'b0, 4'h0, 1'b0, zero);
        key(4'h9, 0, 0, 16'h0009, 3'd1, 4'h0, 1, 0, 0);
        key(4'h8, 0, 0, 16'h0098, 3'd2, 4'h0, 1, 0, 0);
        key(4'h7, 0, 0, 16'h0987, 3'd3, 4'h0, 1, 0, 0);
        key(4'h6, 0, 0, 16'h9876, 3'd4, 4'h0, 1, 0, 0);
        key(4'h5, 0, 0, 16'h9876, 3'd4, 4'h0, 1, 1, 0);
        key(4'hE, 0, 0, 16'h0000, 3'd0, 4'h0, 0, 0, 0);
        key(4'h4, 0, 0, 16'h0004, 3'd1, 4'h0, 1, 0, 0);
        key(4'h2, 0, 0, 16'h0042, 3'd2, 4'h0, 1, 0, 0);
        key(4'hE, 0, 0, 16'h0000, 3'd0, 4'h0, 0, 0, 0);
        key(4'h7, 0, 0, 16'h0007, 3'd1, 4'h0, 1, 0, 0);
        key(4'hF, 0, 1, 16'h0007, 3'd1, 4'hF, 1, 0, 0);
        add(1'b0, 4'h0, 1'b1, zero);
        key(4'hF, 0, 0, 16'h0000, 3'd0, 4'h0, 0, 0, 0);
        key(4'hB, 0, 1, 16'h0000, 3'd0, 4'hB, 1, 0, 0);
        add(1'b0, 4'h0, 1'b1, zero);
        key(4'h1, 0, 0, 16'h0001, 3'd1, 4'h0, 1, 0, 0);
        key(4'hC, 0, 1, 16'h0001, 3'd1, 4'hC, 1, 0, 0);
        key(4'h5, 0, 1, 16'h0001, 3'd1, 4'hC, 1, 0, 1);
        key(4'h5, 1, 0, 16'h0000, 3'd0, 4'h0, 0, 0, 1);

        rst = 1'b1;
        step();
        step();
        chk("reset_state", {4'h0, act()}, {4'h0, zero});
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            key_valid = vecs[i].kv;
            key_code  = vecs[i].code;
            out_ready = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d", i), {4'h0, act()}, {4'h0, vecs[i].exp});
        end
        out_ready = 1'b0;

        // Key held high across reset release must not register.
        key_valid = 1'b1;
        key_code  = 4'h7;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        step();
        chk("held_through_reset", {4'h0, act()}, {4'h0, zero});
        key_valid = 1'b0;
        step();
        key_valid = 1'b1;
        step();
        chk("after_reset_key", {4'h0, act()}, {4'h0, pk(0, 16'h0007, 3'd1, 4'h0, 1, 0, 0, 0)});
        key_valid = 1'b0;
        step();
        key_code  = 4'hE;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        step();

        // Reset while an entry is held discards it.
        key_code  = 4'hA;
        key_valid = 1'b1;
        step();
        chk("hold_before_rst", {4'h0, act()}, {4'h0, pk(1, 16'h0000, 3'd0, 4'hA, 1, 0, 0, 0)});
        key_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_in_hold", {4'h0, act()}, {4'h0, zero});
        step();
        chk("rst_in_hold_after", {4'h0, act()}, {4'h0, zero});

        // Inactivity: key 3 then idle.
        key_code  = 4'h3;
        key_valid = 1'b1;
        step();
        chk("to_key_busy", {31'h0, busy}, 32'd1);
        key_valid = 1'b0;
        pulses = 0;
        pulse_at = -1;
        for (int j = 1; j <= 60; j++) begin
            step();
            if (timeout) begin
                pulses++;
                pulse_at = j;
            end
        end
`ifdef ENTRY_TIMEOUT_EN
        chk("to_pulses", pulses, 1);
        chk("to_pulse_cycle", pulse_at, 50);
        chk("to_after", {29'h0, busy, out_count[1:0]}, 32'd0);
`else
        chk("to_pulses", pulses, 0);
        chk("to_after", {28'h0, busy, out_count}, 32'h9);
`endif
        key_code  = 4'hE;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        step();
        chk("final_clear", {4'h0, act()}, {4'h0, zero});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
